// File: rtl/sparce_svc_mlane.sv
// SpaRCE multi-lane sparsity value checker: per-lane zero flags and a per-register zero bitmap.
// Optional per-lane saturating statistics counters are built when SPARCE_SVC_STATS_EN is defined.

module sparce_svc_lane #(
   parameter int DATA_WIDTH = 32
`ifdef SPARCE_SVC_STATS_EN
   ,
   parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  zero,
   output logic                  is_sparse,
   output logic                  is_sparse_valid
`ifdef SPARCE_SVC_STATS_EN
   ,
   input  logic                  stat_clear,
   output logic [CNT_WIDTH-1:0]  stat_sparse,
   output logic [CNT_WIDTH-1:0]  stat_total
`endif
);

   assign zero = (data == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_sparse       <= 1'b0;
         is_sparse_valid <= 1'b0;
      end else begin
         is_sparse       <= valid & zero;
         is_sparse_valid <= valid;
      end
   end

`ifdef SPARCE_SVC_STATS_EN
   // Clear beats increment; counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_sparse <= '0;
         stat_total  <= '0;
      end else if (stat_clear) begin
         stat_sparse <= '0;
         stat_total  <= '0;
      end else begin
         if (valid && stat_total != '1)
            stat_total <= stat_total + 1'b1;
         if (valid && zero && stat_sparse != '1)
            stat_sparse <= stat_sparse + 1'b1;
      end
   end
`endif

endmodule

module sparce_svc_mlane #(
   parameter  int DATA_WIDTH = 32,
   parameter  int LANES      = 2,
   parameter  int NUM_REGS   = 32,
   parameter  int CNT_WIDTH  = 16,
   localparam int REG_W      = $clog2(NUM_REGS)
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [LANES-1:0]              wb_valid,
   input  logic [LANES*REG_W-1:0]        wb_rd,
   input  logic [LANES*DATA_WIDTH-1:0]   wb_data,
   input  logic                          flush,
   output logic [LANES-1:0]              is_sparse,
   output logic [LANES-1:0]              is_sparse_valid,
   output logic [NUM_REGS-1:0]           sparse_map
`ifdef SPARCE_SVC_STATS_EN
   ,
   input  logic                          stat_clear,
   output logic [LANES*CNT_WIDTH-1:0]    stat_sparse,
   output logic [LANES*CNT_WIDTH-1:0]    stat_total
`endif
);

   localparam logic [REG_W:0] NUM_REGS_EXT = (REG_W+1)'(NUM_REGS);

   if (LANES < 1 || NUM_REGS < 2 || CNT_WIDTH < 1 || DATA_WIDTH < 1) begin : g_cfg_err
      $error("sparce_svc_mlane: illegal parameter set");
   end

   logic [LANES-1:0][REG_W-1:0]      lane_rd;
   logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;
   logic [LANES-1:0]                 lane_z;
   logic [NUM_REGS-1:0]              map_q;
   logic [NUM_REGS-1:0]              map_nxt;

   assign lane_rd   = wb_rd;
   assign lane_data = wb_data;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SPARCE_SVC_STATS_EN
      sparce_svc_lane #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_lane (
         .clk             (CLK),
         .rst             (RST),
         .valid           (wb_valid[i]),
         .data            (lane_data[i]),
         .zero            (lane_z[i]),
         .is_sparse       (is_sparse[i]),
         .is_sparse_valid (is_sparse_valid[i]),
         .stat_clear      (stat_clear),
         .stat_sparse     (stat_sparse[i*CNT_WIDTH +: CNT_WIDTH]),
         .stat_total      (stat_total[i*CNT_WIDTH +: CNT_WIDTH])
      );
`else
      sparce_svc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .clk             (CLK),
         .rst             (RST),
         .valid           (wb_valid[i]),
         .data            (lane_data[i]),
         .zero            (lane_z[i]),
         .is_sparse       (is_sparse[i]),
         .is_sparse_valid (is_sparse_valid[i])
      );
`endif
   end

   // Ascending lane walk lets the youngest lane win same-register collisions.
   always_comb begin
      map_nxt = map_q;
      for (int i = 0; i < LANES; i++) begin
         if (wb_valid[i] && lane_rd[i] != '0 && {1'b0, lane_rd[i]} < NUM_REGS_EXT)
            map_nxt[lane_rd[i]] = lane_z[i];
      end
      if (flush)
         map_nxt = '0;
      map_nxt[0] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         map_q <= NUM_REGS'(1);
      else
         map_q <= map_nxt;
   end

   assign sparse_map = map_q;

endmodule

// File: tb/tb_sparce_svc_mlane.sv
// Directed self-checking bench for sparce_svc_mlane (2 lanes, 32 regs, 4-bit counters when
// SPARCE_SVC_STATS_EN is defined).

module tb_sparce_svc_mlane;

   localparam int DW = 32;
   localparam int LN = 2;
   localparam int NR = 32;
   localparam int CW = 4;
   localparam int RW = 5;

   logic              CLK = 1'b0;
   logic              RST;
   logic [LN-1:0]     wb_valid;
   logic [LN*RW-1:0]  wb_rd;
   logic [LN*DW-1:0]  wb_data;
   logic              flush;
   logic [LN-1:0]     is_sparse;
   logic [LN-1:0]     is_sparse_valid;
   logic [NR-1:0]     sparse_map;
`ifdef SPARCE_SVC_STATS_EN
   logic              stat_clear;
   logic [LN*CW-1:0]  stat_sparse;
   logic [LN*CW-1:0]  stat_total;
`endif

   int checks = 0;
   int failures = 0;

   sparce_svc_mlane #(.DATA_WIDTH(DW), .LANES(LN), .NUM_REGS(NR), .CNT_WIDTH(CW)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .flush           (flush),
      .is_sparse       (is_sparse),
      .is_sparse_valid (is_sparse_valid),
      .sparse_map      (sparse_map)
`ifdef SPARCE_SVC_STATS_EN
      ,
      .stat_clear      (stat_clear),
      .stat_sparse     (stat_sparse),
      .stat_total      (stat_total)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input int l, input logic v, input int rd, input logic [DW-1:0] d);
      logic [RW-1:0] r;
      r = rd[RW-1:0];
      wb_valid[l]          = v;
      wb_rd[l*RW +: RW]    = r;
      wb_data[l*DW +: DW]  = d;
   endtask

   task automatic idle();
      wb_valid = '0;
      wb_rd    = '0;
      wb_data  = '0;
      flush    = 1'b0;
`ifdef SPARCE_SVC_STATS_EN
      stat_clear = 1'b0;
`endif
   endtask

   // Apply the current inputs on one rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1;
      idle();
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_map", 64'(sparse_map), 64'h1);
      chk("rst_sparse", 64'(is_sparse), 64'h0);
      chk("rst_valid", 64'(is_sparse_valid), 64'h0);
`ifdef SPARCE_SVC_STATS_EN
      chk("rst_stat_sparse", 64'(stat_sparse), 64'h0);
      chk("rst_stat_total", 64'(stat_total), 64'h0);
`endif
      RST = 1'b0;

      // single lane set then clear x5
      drv(0, 1'b1, 5, 32'h0);
      step();
      chk("x5_zero_map", 64'(sparse_map), 64'h21);
      chk("x5_zero_sparse", 64'(is_sparse), 64'h1);
      chk("x5_zero_valid", 64'(is_sparse_valid), 64'h1);
      drv(0, 1'b1, 5, 32'h7);
      step();
      chk("x5_nz_map", 64'(sparse_map), 64'h1);
      chk("x5_nz_sparse", 64'(is_sparse), 64'h0);

      // collision on x3, youngest lane wins
      drv(0, 1'b1, 3, 32'h0);
      drv(1, 1'b1, 3, 32'h9);
      step();
      chk("coll_a_map", 64'(sparse_map), 64'h1);
      chk("coll_a_sparse", 64'(is_sparse), 64'h1);
      chk("coll_a_valid", 64'(is_sparse_valid), 64'h3);
      drv(0, 1'b1, 3, 32'h9);
      drv(1, 1'b1, 3, 32'h0);
      step();
      chk("coll_b_map", 64'(sparse_map), 64'h9);
      chk("coll_b_sparse", 64'(is_sparse), 64'h2);

      // write to x0 is ignored; top-bit-only nonzero data is not sparse
      drv(0, 1'b1, 0, 32'h5);
      drv(1, 1'b1, 3, 32'h8000_0000);
      step();
      chk("x0_map", 64'(sparse_map), 64'h1);
      chk("x0_sparse", 64'(is_sparse), 64'h0);

      // fill x1..x31 with zero, two per cycle
      for (int r = 1; r < NR; r += 2) begin
         drv(0, 1'b1, r, 32'h0);
         if (r + 1 < NR) drv(1, 1'b1, r + 1, 32'h0);
         else            drv(1, 1'b0, 0, 32'h0);
         step();
      end
      chk("fill_map", 64'(sparse_map), 64'hFFFF_FFFF);

      // flush beats same-cycle write, but lane flags still report
      drv(0, 1'b0, 0, 32'h0);
      drv(1, 1'b1, 4, 32'h0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_map", 64'(sparse_map), 64'h1);
      chk("flush_sparse", 64'(is_sparse), 64'h2);
      chk("flush_valid", 64'(is_sparse_valid), 64'h2);

      // asynchronous reset mid-stream
      drv(1, 1'b0, 0, 32'h0);
      drv(0, 1'b1, 5, 32'h0);
      step();
      chk("pre_arst_map", 64'(sparse_map), 64'h21);
      idle();
      #1 RST = 1'b1;
      #1;
      chk("arst_map", 64'(sparse_map), 64'h1);
      chk("arst_sparse", 64'(is_sparse), 64'h0);
      #1 RST = 1'b0;

      // 20 sparse writes on lane1 to x6
      drv(1, 1'b1, 6, 32'h0);
      step();
      chk("l1_first_map", 64'(sparse_map), 64'h41);
      chk("l1_first_sparse", 64'(is_sparse), 64'h2);
`ifdef SPARCE_SVC_STATS_EN
      chk("cnt_one_sparse", 64'(stat_sparse[CW +: CW]), 64'h1);
      chk("cnt_one_total", 64'(stat_total[CW +: CW]), 64'h1);
`endif
      repeat (19) step();
      chk("l1_20_map", 64'(sparse_map), 64'h41);
`ifdef SPARCE_SVC_STATS_EN
      chk("cnt_sat_sparse", 64'(stat_sparse[CW +: CW]), 64'hF);
      chk("cnt_sat_total", 64'(stat_total[CW +: CW]), 64'hF);
      chk("cnt_lane0_sparse", 64'(stat_sparse[0 +: CW]), 64'h0);
      stat_clear = 1'b1;
      step();
      stat_clear = 1'b0;
      chk("cnt_clr_sparse", 64'(stat_sparse[CW +: CW]), 64'h0);
      chk("cnt_clr_total", 64'(stat_total[CW +: CW]), 64'h0);
      drv(1, 1'b1, 6, 32'h3);
      step();
      chk("cnt_post_sparse", 64'(stat_sparse[CW +: CW]), 64'h0);
      chk("cnt_post_total", 64'(stat_total[CW +: CW]), 64'h1);
`else
      drv(1, 1'b1, 6, 32'h3);
      step();
`endif
      chk("l1_nz_map", 64'(sparse_map), 64'h1);
      chk("l1_nz_sparse", 64'(is_sparse), 64'h0);
      idle();
      step();
      chk("idle_valid", 64'(is_sparse_valid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sparce_svc_mlane.md
# sparce_svc_mlane

Multi-lane, registered sparsity value checker for the SpaRCE sparsity framework. Each cycle it examines up to LANES writeback results, flags each zero-valued result, and keeps a per-architectural-register sparsity bitmap marking registers whose most recent write was zero. It sits beside the writeback stage(s), and its bitmap feeds the SpaRCE skip-detection logic. Optional per-lane saturating statistics counters support sparsity profiling.

## Interface
- DATA_WIDTH, 32, width of one writeback datum
- LANES, 2, number of writeback lanes; lane LANES-1 is youngest in program order
- NUM_REGS, 32, architectural registers tracked; register 0 is hardwired zero
- CNT_WIDTH, 16, width of each statistics counter
- REG_W, $clog2(NUM_REGS), derived localparam; not overridable

Ports:
- CLK  in  1  clock; all state updates on its rising edge
- RST  in  1  reset, asynchronous, active-high
- wb_valid  in  LANES  lane i carries a real writeback this cycle
- wb_rd  in  LANES*REG_W  destination index; lane i at bits [i*REG_W +: REG_W]
- wb_data  in  LANES*DATA_WIDTH  writeback value; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- flush  in  1  clears the bitmap (context switch or pipeline squash of architectural state)
- is_sparse  out  LANES  registered: lane i's previous-cycle writeback was zero
- is_sparse_valid  out  LANES  registered copy of wb_valid
- sparse_map  out  NUM_REGS  bit r = 1 means register r currently holds zero
- stat_clear  in  1  zeroes all statistics counters (present only with SPARCE_SVC_STATS_EN)
- stat_sparse  out  LANES*CNT_WIDTH  per-lane count of sparse writebacks (present only with SPARCE_SVC_STATS_EN)
- stat_total  out  LANES*CNT_WIDTH  per-lane count of valid writebacks (present only with SPARCE_SVC_STATS_EN)

## Operation
- Zero detect per lane: z[i] = (wb_data lane i == 0), full DATA_WIDTH compare.
- is_sparse[i] <= wb_valid[i] & z[i]; is_sparse_valid[i] <= wb_valid[i].
- Bitmap update for valid lane i with wb_rd != 0: bit[wb_rd] <= z[i]. Writes to register 0 are ignored.
- Same destination on several lanes in one cycle: the highest-index valid lane wins.
- sparse_map[0] is constant 1.
- flush: bits 1..NUM_REGS-1 <= 0. Flush overrides all same-cycle bitmap writes. is_sparse, is_sparse_valid and the counters still update normally.
- Counters (lane i, when enabled): stat_total increments on wb_valid[i]; stat_sparse increments on wb_valid[i] & z[i]. Both saturate at all-ones and do not wrap. stat_clear has priority over a same-cycle increment, so the counter becomes 0.
- wb_rd values >= NUM_REGS (non-power-of-two NUM_REGS only) are ignored for the bitmap and still reported on is_sparse.

## Timing
- Reset values: is_sparse = 0, is_sparse_valid = 0, sparse_map = 1 (only bit 0 set), all counters 0.
- RST is asynchronous: asserting it mid-operation clears state immediately. The first update happens on the first rising CLK after RST deasserts.
- Latency: inputs at edge N are visible on is_sparse, sparse_map and the counters after edge N+1, i.e. one cycle.
- No input-to-output combinational path.
- No backpressure. Every valid lane is consumed in the cycle it is presented.

## Configuration
- SPARCE_SVC_STATS_EN defined: stat_clear, stat_sparse and stat_total ports exist, and the 2*LANES saturating counters are instantiated.
- SPARCE_SVC_STATS_EN undefined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset: hold RST, then release -> sparse_map == 32'h0000_0001, is_sparse == 0, counters 0. Assert RST mid-stream after x5 has been set -> map returns to 32'h1 immediately, without waiting for a clock edge.
- Single lane: lane0 writes x5 = 0 -> next cycle is_sparse[0] = 1 and map[5] = 1. Lane0 then writes x5 = 7 -> map[5] = 0 and is_sparse[0] = 0.
- Collision: lane0 writes x3 = 0 and lane1 writes x3 = 9 in the same cycle -> map[3] = 0, is_sparse = 2'b01. Swap the values -> map[3] = 1.
- x0 and flush: lane0 writes x0 = 5 -> map[0] stays 1. Set x1..x31 to zero, then flush together with lane1 writing x4 = 0 -> map == 32'h1, is_sparse[1] = 1.
- Counters (with SPARCE_SVC_STATS_EN, CNT_WIDTH = 4): 20 sparse writes on lane1 -> stat_sparse lane1 = 4'hF with no wrap. stat_clear together with a write -> 0.
- Build without SPARCE_SVC_STATS_EN: the same directed sequences give an identical is_sparse and sparse_map trace.
